// File: rtl/arbitration_sub_module.sv
// Per-core bus isolation: gates data/instruction bus signals on arbiter grant, raises one request per bus.
// Zero-latency combinational forwarding; requests are held until transfer completion or grant loss.
module arbitration_sub_module #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 30,
    parameter int WE_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // data channel
    input  logic [DATA_W-1:0] Bus_DataMem_In,
    input  logic              Bus_DataMem_Ready,
    input  logic              P_DataMem_Read,
    input  logic [WE_W-1:0]   P_DataMem_Write,
    input  logic [ADDR_W-1:0] P_DataMem_Address,
    input  logic [DATA_W-1:0] P_DataMem_Out,
    output logic [DATA_W-1:0] P_DataMem_In,
    output logic              P_DataMem_Ready,
    output logic              Bus_DataMem_Read,
    output logic [WE_W-1:0]   Bus_DataMem_Write,
    output logic [ADDR_W-1:0] Bus_DataMem_Address,
    output logic [DATA_W-1:0] Bus_DataMem_Out,
    output logic              D_Bus_RQ,
    input  logic              D_Bus_GRANT,
    // instruction channel
    input  logic              Bus_InstMem_Ready,
    input  logic [DATA_W-1:0] Bus_InstMem_In,
    input  logic [ADDR_W-1:0] P_InstMem_Address,
    input  logic              P_InstMem_Read,
    output logic              P_InstMem_Ready,
    output logic [DATA_W-1:0] P_InstMem_In,
    output logic [ADDR_W-1:0] Bus_InstMem_Address,
    output logic              Bus_InstMem_Read,
    output logic              I_Bus_RQ,
    input  logic              I_Bus_GRANT
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } chan_state_t;

    chan_state_t d_state;
    chan_state_t i_state;
    logic        d_req;
    logic        i_req;

    assign d_req = P_DataMem_Read | (|P_DataMem_Write);
    assign i_req = P_InstMem_Read;

    // ACTIVE ends on completion or on grant loss; a revoked transfer is dropped, not retried.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_state <= IDLE;
        end else begin
            case (d_state)
                IDLE:    if (d_req && D_Bus_GRANT) d_state <= ACTIVE;
                ACTIVE:  if (!D_Bus_GRANT || Bus_DataMem_Ready) d_state <= IDLE;
                default: d_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_state <= IDLE;
        end else begin
            case (i_state)
                IDLE:    if (i_req && I_Bus_GRANT) i_state <= ACTIVE;
                ACTIVE:  if (!I_Bus_GRANT || Bus_InstMem_Ready) i_state <= IDLE;
                default: i_state <= IDLE;
            endcase
        end
    end

    // In IDLE the request tracks the strobe so a new access is visible the same cycle.
    assign D_Bus_RQ = (d_state == ACTIVE) | d_req;
    assign I_Bus_RQ = (i_state == ACTIVE) | i_req;

    assign Bus_DataMem_Read    = D_Bus_GRANT & P_DataMem_Read;
    assign Bus_DataMem_Write   = D_Bus_GRANT ? P_DataMem_Write   : '0;
    assign Bus_DataMem_Address = D_Bus_GRANT ? P_DataMem_Address : '0;
    assign Bus_DataMem_Out     = D_Bus_GRANT ? P_DataMem_Out     : '0;
    assign P_DataMem_In        = D_Bus_GRANT ? Bus_DataMem_In    : '0;
    assign P_DataMem_Ready     = D_Bus_GRANT & Bus_DataMem_Ready;

    assign Bus_InstMem_Read    = I_Bus_GRANT & P_InstMem_Read;
    assign Bus_InstMem_Address = I_Bus_GRANT ? P_InstMem_Address : '0;
    assign P_InstMem_In        = I_Bus_GRANT ? Bus_InstMem_In    : '0;
    assign P_InstMem_Ready     = I_Bus_GRANT & Bus_InstMem_Ready;

endmodule

// File: tb/tb_arbitration_sub_module.sv
// Directed plus randomized checks of arbitration_sub_module against a per-channel outstanding-transfer model.
module tb_arbitration_sub_module;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 30;
    localparam int WE_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] Bus_DataMem_In;
    logic              Bus_DataMem_Ready;
    logic              P_DataMem_Read;
    logic [WE_W-1:0]   P_DataMem_Write;
    logic [ADDR_W-1:0] P_DataMem_Address;
    logic [DATA_W-1:0] P_DataMem_Out;
    logic [DATA_W-1:0] P_DataMem_In;
    logic              P_DataMem_Ready;
    logic              Bus_DataMem_Read;
    logic [WE_W-1:0]   Bus_DataMem_Write;
    logic [ADDR_W-1:0] Bus_DataMem_Address;
    logic [DATA_W-1:0] Bus_DataMem_Out;
    logic              D_Bus_RQ;
    logic              D_Bus_GRANT;
    logic              Bus_InstMem_Ready;
    logic [DATA_W-1:0] Bus_InstMem_In;
    logic [ADDR_W-1:0] P_InstMem_Address;
    logic              P_InstMem_Read;
    logic              P_InstMem_Ready;
    logic [DATA_W-1:0] P_InstMem_In;
    logic [ADDR_W-1:0] Bus_InstMem_Address;
    logic              Bus_InstMem_Read;
    logic              I_Bus_RQ;
    logic              I_Bus_GRANT;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    // one bit per channel: a granted transfer has started and not yet finished
    bit d_busy = 1'b0;
    bit i_busy = 1'b0;

    always #5 clk = ~clk;

    arbitration_sub_module #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WE_W(WE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Bus_DataMem_In(Bus_DataMem_In), .Bus_DataMem_Ready(Bus_DataMem_Ready),
        .P_DataMem_Read(P_DataMem_Read), .P_DataMem_Write(P_DataMem_Write),
        .P_DataMem_Address(P_DataMem_Address), .P_DataMem_Out(P_DataMem_Out),
        .P_DataMem_In(P_DataMem_In), .P_DataMem_Ready(P_DataMem_Ready),
        .Bus_DataMem_Read(Bus_DataMem_Read), .Bus_DataMem_Write(Bus_DataMem_Write),
        .Bus_DataMem_Address(Bus_DataMem_Address), .Bus_DataMem_Out(Bus_DataMem_Out),
        .D_Bus_RQ(D_Bus_RQ), .D_Bus_GRANT(D_Bus_GRANT),
        .Bus_InstMem_Ready(Bus_InstMem_Ready), .Bus_InstMem_In(Bus_InstMem_In),
        .P_InstMem_Address(P_InstMem_Address), .P_InstMem_Read(P_InstMem_Read),
        .P_InstMem_Ready(P_InstMem_Ready), .P_InstMem_In(P_InstMem_In),
        .Bus_InstMem_Address(Bus_InstMem_Address), .Bus_InstMem_Read(Bus_InstMem_Read),
        .I_Bus_RQ(I_Bus_RQ), .I_Bus_GRANT(I_Bus_GRANT)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit d_wants();
        return P_DataMem_Read || (P_DataMem_Write != '0);
    endfunction

    // A transfer starts when a request meets a grant; it survives only while granted and not yet ready.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_busy <= 1'b0;
            i_busy <= 1'b0;
        end else begin
            d_busy <= d_busy ? (D_Bus_GRANT && !Bus_DataMem_Ready) : (d_wants() && D_Bus_GRANT);
            i_busy <= i_busy ? (I_Bus_GRANT && !Bus_InstMem_Ready) : (P_InstMem_Read && I_Bus_GRANT);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_d_rq", D_Bus_RQ, d_busy || d_wants());
            check("m_i_rq", I_Bus_RQ, i_busy || P_InstMem_Read);
            check("m_bd_rd", Bus_DataMem_Read, D_Bus_GRANT ? P_DataMem_Read : 1'b0);
            check("m_bd_we", Bus_DataMem_Write, D_Bus_GRANT ? P_DataMem_Write : '0);
            check("m_bd_ad", Bus_DataMem_Address, D_Bus_GRANT ? P_DataMem_Address : '0);
            check("m_bd_out", Bus_DataMem_Out, D_Bus_GRANT ? P_DataMem_Out : '0);
            check("m_pd_in", P_DataMem_In, D_Bus_GRANT ? Bus_DataMem_In : '0);
            check("m_pd_rdy", P_DataMem_Ready, D_Bus_GRANT ? Bus_DataMem_Ready : 1'b0);
            check("m_bi_rd", Bus_InstMem_Read, I_Bus_GRANT ? P_InstMem_Read : 1'b0);
            check("m_bi_ad", Bus_InstMem_Address, I_Bus_GRANT ? P_InstMem_Address : '0);
            check("m_pi_in", P_InstMem_In, I_Bus_GRANT ? Bus_InstMem_In : '0);
            check("m_pi_rdy", P_InstMem_Ready, I_Bus_GRANT ? Bus_InstMem_Ready : 1'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WE_W-1:0] pat;
        rst_n = 1'b0;
        Bus_DataMem_In = '0; Bus_DataMem_Ready = 1'b0; P_DataMem_Read = 1'b0;
        P_DataMem_Write = '0; P_DataMem_Address = '0; P_DataMem_Out = '0; D_Bus_GRANT = 1'b0;
        Bus_InstMem_Ready = 1'b0; Bus_InstMem_In = '0; P_InstMem_Address = '0;
        P_InstMem_Read = 1'b0; I_Bus_GRANT = 1'b0;
        #2;
        check("rst_d_rq", D_Bus_RQ, 1'b0);
        check("rst_i_rq", I_Bus_RQ, 1'b0);
        #10 rst_n = 1'b1;
        chk_en = 1'b1;

        // no grant: request raised, everything isolated
        step();
        P_DataMem_Address = 31; P_DataMem_Out = 127; Bus_DataMem_In = 63; P_DataMem_Read = 1'b1;
        #1;
        check("ng_rq", D_Bus_RQ, 1'b1);
        check("ng_addr", Bus_DataMem_Address, 0);
        check("ng_out", Bus_DataMem_Out, 0);
        check("ng_rd", Bus_DataMem_Read, 1'b0);
        check("ng_in", P_DataMem_In, 0);
        D_Bus_GRANT = 1'b1;
        #1;
        check("g_addr", Bus_DataMem_Address, 31);
        check("g_out", Bus_DataMem_Out, 127);
        check("g_rd", Bus_DataMem_Read, 1'b1);
        check("g_in", P_DataMem_In, 63);
        step();
        D_Bus_GRANT = 1'b0;
        #1;
        check("ug_addr", Bus_DataMem_Address, 0);
        check("ug_in", P_DataMem_In, 0);
        check("ug_rq", D_Bus_RQ, 1'b1);
        step();
        P_DataMem_Read = 1'b0;
        #1;
        check("ug_idle_rq", D_Bus_RQ, 1'b0);

        // each single byte enable is a request on its own
        for (int i = 0; i < WE_W; i++) begin
            step();
            pat = WE_W'(1) << i;
            P_DataMem_Write = pat;
            #1;
            check("grp_rq", D_Bus_RQ, 1'b1);
        end
        step();
        P_DataMem_Write = '0;
        #1;
        check("grp_none", D_Bus_RQ, 1'b0);
        P_DataMem_Write = 4'b0100; D_Bus_GRANT = 1'b1;
        #1;
        check("grp_we", Bus_DataMem_Write, 4'b0100);
        D_Bus_GRANT = 1'b0;
        step();
        P_DataMem_Write = '0;

        // instruction request held after the strobe drops
        step();
        P_InstMem_Read = 1'b1; I_Bus_GRANT = 1'b1;
        step();
        P_InstMem_Read = 1'b0;
        #1;
        check("ih_rq", I_Bus_RQ, 1'b1);
        Bus_InstMem_Ready = 1'b1; Bus_InstMem_In = 1023;
        #1;
        check("ih_rdy", P_InstMem_Ready, 1'b1);
        check("ih_in", P_InstMem_In, 1023);
        step();
        check("ih_done_rq", I_Bus_RQ, 1'b0);

        // ready isolation, then grant revoked mid-transfer
        I_Bus_GRANT = 1'b0;
        #1;
        check("iso_rdy", P_InstMem_Ready, 1'b0);
        check("iso_in", P_InstMem_In, 0);
        step();
        Bus_InstMem_Ready = 1'b0; P_InstMem_Read = 1'b1; I_Bus_GRANT = 1'b1;
        step();
        I_Bus_GRANT = 1'b0; P_InstMem_Read = 1'b0;
        #1;
        check("rev_hold", I_Bus_RQ, 1'b1);
        step();
        check("rev_idle", I_Bus_RQ, 1'b0);
        P_InstMem_Read = 1'b1;
        #1;
        check("rev_req", I_Bus_RQ, 1'b1);
        P_InstMem_Read = 1'b0;

        // asynchronous reset drops a held request without a clock edge
        step();
        P_DataMem_Read = 1'b1; D_Bus_GRANT = 1'b1; Bus_DataMem_Ready = 1'b0;
        step();
        P_DataMem_Read = 1'b0;
        #1;
        check("ar_hold", D_Bus_RQ, 1'b1);
        rst_n = 1'b0;
        #1;
        check("ar_drop", D_Bus_RQ, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        check("ar_rel", D_Bus_RQ, 1'b0);
        step();
        check("ar_idle", D_Bus_RQ, 1'b0);
        D_Bus_GRANT = 1'b0;

        // random traffic, occasional resets; the negedge checker compares every cycle
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst_n = ($urandom_range(0, 99) != 0);
            D_Bus_GRANT = $urandom_range(0, 2) != 0;
            I_Bus_GRANT = $urandom_range(0, 2) != 0;
            P_DataMem_Read = $urandom_range(0, 2) == 0;
            P_DataMem_Write = ($urandom_range(0, 3) == 0) ? WE_W'($urandom) : '0;
            P_DataMem_Address = ADDR_W'($urandom);
            P_DataMem_Out = $urandom;
            Bus_DataMem_In = $urandom;
            Bus_DataMem_Ready = $urandom_range(0, 3) == 0;
            P_InstMem_Read = $urandom_range(0, 2) == 0;
            P_InstMem_Address = ADDR_W'($urandom);
            Bus_InstMem_In = $urandom;
            Bus_InstMem_Ready = $urandom_range(0, 3) == 0;
        end
        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/arbitration_sub_module.md
Name: arbitration_sub_module

Overview:
- Per-core bus isolation and request unit between one processor core and the shared data bus and instruction bus.
- Collapses the processor's per-bus access strobes into one request line per bus toward the central bus arbiter.
- Forwards processor⇄bus signals only while the arbiter's grant for that bus is asserted; otherwise drives all forwarded signals to zero.
- Data and instruction channels are independent and identical in structure.

Parameters:
- DATA_W, 32, data width of both buses.
- ADDR_W, 30, word-address width of both buses.
- WE_W, 4, byte-write-enable width (data bus).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- Bus_DataMem_In  in  DATA_W  read data from data bus
- Bus_DataMem_Ready  in  1  data bus transfer complete
- P_DataMem_Read  in  1  processor data read strobe
- P_DataMem_Write  in  WE_W  processor byte write enables
- P_DataMem_Address  in  ADDR_W  processor data address
- P_DataMem_Out  in  DATA_W  processor write data
- P_DataMem_In  out  DATA_W  read data to processor
- P_DataMem_Ready  out  1  data ready to processor
- Bus_DataMem_Read  out  1  read strobe to data bus
- Bus_DataMem_Write  out  WE_W  write enables to data bus
- Bus_DataMem_Address  out  ADDR_W  address to data bus
- Bus_DataMem_Out  out  DATA_W  write data to data bus
- D_Bus_RQ  out  1  data bus request to arbiter
- D_Bus_GRANT  in  1  data bus granted by arbiter
- Bus_InstMem_Ready  in  1  instruction bus transfer complete
- Bus_InstMem_In  in  DATA_W  instruction from bus
- P_InstMem_Address  in  ADDR_W  processor fetch address
- P_InstMem_Read  in  1  processor fetch strobe
- P_InstMem_Ready  out  1  fetch ready to processor
- P_InstMem_In  out  DATA_W  instruction to processor
- Bus_InstMem_Address  out  ADDR_W  fetch address to bus
- Bus_InstMem_Read  out  1  fetch strobe to bus
- I_Bus_RQ  out  1  instruction bus request to arbiter
- I_Bus_GRANT  in  1  instruction bus granted by arbiter

Behaviour:
- Data request: d_req = P_DataMem_Read | (|P_DataMem_Write).
- Instruction request: i_req = P_InstMem_Read.
- Gating is purely combinational on GRANT, zero latency:
  - GRANT=1: every Bus_* output equals its P_* counterpart; P_*_In = Bus_*_In; P_*_Ready = Bus_*_Ready.
  - GRANT=0: every Bus_* output and P_*_In/P_*_Ready are forced to 0.
  - Bus data and Ready are ignored while ungranted.
- Each channel has an independent 2-state FSM, IDLE/ACTIVE, clocked on the rising edge of clk.
  - IDLE: RQ = req, combinational. Next state is ACTIVE if req & GRANT, else IDLE.
  - ACTIVE: RQ = 1 (request held until completion even if the processor strobe drops).
  - ACTIVE → IDLE when GRANT & Bus_Ready (transfer done), or when GRANT=0 (grant revoked: abort; no retry generated by this block).
  - In ACTIVE, if GRANT & Bus_Ready & req in the same cycle, go to IDLE; RQ follows req combinationally next cycle (back-to-back allowed).
- Grant without request: signals still forwarded (zeros/idle from processor); FSM stays IDLE; RQ=0.
- Request without grant: RQ=1, processor sees Ready=0 and In=0 indefinitely; stalling is the processor's responsibility.
- Simultaneous data and instruction activity is fully independent; no cross-channel interaction.
- Reset (asynchronous assert, synchronous-to-clk release): both FSMs go to IDLE immediately. Mid-transaction reset drops the held RQ the same instant unless req is still asserted. Gating outputs are unaffected by reset; they are combinational.
- No widths change across the block; signals pass through bit-for-bit.

Test Plan:
- No grant: P_DataMem_Address=31, P_DataMem_Out=127, Bus_DataMem_In=63, P_DataMem_Read=1 → D_Bus_RQ=1; Bus_DataMem_Address=0, Bus_DataMem_Out=0, Bus_DataMem_Read=0, P_DataMem_In=0.
- Grant data: D_Bus_GRANT=1 with read pending → Bus_DataMem_Address=31, Bus_DataMem_Out=127, Bus_DataMem_Read=1, P_DataMem_In=63 same cycle. Deassert GRANT → all return to 0.
- Request grouping: P_DataMem_Write = 0001, 0010, 0100, 1000 in turn with Read=0 → D_Bus_RQ=1 each; Write=0000 and Read=0 in IDLE → D_Bus_RQ=0. When granted, Bus_DataMem_Write equals the applied pattern.
- Instruction hold: P_InstMem_Read=1, I_Bus_GRANT=1, one clk edge, then Read=0 → I_Bus_RQ stays 1. Bus_InstMem_Ready=1 with In=1023 → P_InstMem_Ready=1, P_InstMem_In=1023; next edge → I_Bus_RQ=0.
- Ready isolation: Bus_InstMem_Ready=1, I_Bus_GRANT=0 → P_InstMem_Ready=0, P_InstMem_In=0; grant revoked while ACTIVE → FSM IDLE next edge, RQ=req.
- Async reset: rst_n=0 while data channel ACTIVE and strobes low → D_Bus_RQ=0 without a clock edge; after release, FSM is IDLE.
